// File: rtl/fir_mac_sequencer.sv
// Shared-MAC FIR bank: NUM_FILTERS filters of NUM_ELEM taps evaluated one tap per cycle over one delay line.
// Optional FIR_SEQ_STALL_CNT_EN adds o_stall_cnt (saturating count of source stall cycles).
module fir_mac_sequencer #(
    parameter  int BITS_PER_ELEM = 8,
    parameter  int NUM_ELEM      = 7,
    parameter  int NUM_FILTERS   = 4,
    localparam int ACC_W         = 2*BITS_PER_ELEM + $clog2(NUM_ELEM),
    localparam int FID_W         = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst_n,
    input  logic [BITS_PER_ELEM-1:0]                    i_sample,
    input  logic                                        i_sample_valid,
    output logic                                        o_sample_ready,
    input  logic [NUM_FILTERS*NUM_ELEM*BITS_PER_ELEM-1:0] i_coeffs,
    output logic [ACC_W-1:0]                            o_result,
    output logic [FID_W-1:0]                            o_filter_id,
    output logic                                        o_valid,
    input  logic                                        i_ready
`ifdef FIR_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]                                 o_stall_cnt
`endif
);

    localparam int TAP_W = $clog2(NUM_ELEM);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_ELEM - 1);
    localparam logic [FID_W-1:0] LAST_FLT = FID_W'(NUM_FILTERS - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                   r_state, w_next;
    logic [BITS_PER_ELEM-1:0] r_delay [NUM_ELEM];
    logic [ACC_W-1:0]         r_acc;
    logic [TAP_W-1:0]         r_tap;
    logic [FID_W-1:0]         r_filter;
    logic [BITS_PER_ELEM-1:0] w_coef;
    logic [BITS_PER_ELEM-1:0] w_tap_val;
    logic [ACC_W-1:0]         w_product;
    logic [ACC_W-1:0]         w_sum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_sample_valid) w_next = S_MAC;
            S_MAC:  if (r_tap == LAST_TAP) w_next = S_OUT;
            S_OUT:  if (i_ready) w_next = (r_filter == LAST_FLT) ? S_IDLE : S_MAC;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_sample_ready = (r_state == S_IDLE);
    end

    // Explicit mux keeps out-of-range tap/filter codes harmless for non-power-of-2 sizes.
    always_comb begin
        w_coef    = '0;
        w_tap_val = '0;
        for (int unsigned k = 0; k < NUM_ELEM; k++) begin
            if (r_tap == TAP_W'(k)) w_tap_val = r_delay[k];
            for (int unsigned f = 0; f < NUM_FILTERS; f++) begin
                if (r_tap == TAP_W'(k) && r_filter == FID_W'(f))
                    w_coef = i_coeffs[BITS_PER_ELEM*(f*NUM_ELEM + k) +: BITS_PER_ELEM];
            end
        end
    end

    assign w_product = ACC_W'(w_coef) * ACC_W'(w_tap_val);
    assign w_sum     = r_acc + w_product;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned k = 0; k < NUM_ELEM; k++) r_delay[k] <= '0;
            r_acc       <= '0;
            r_tap       <= '0;
            r_filter    <= '0;
            o_result    <= '0;
            o_filter_id <= '0;
            o_valid     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_sample_valid) begin
                        r_delay[0] <= i_sample;
                        for (int unsigned k = NUM_ELEM - 1; k > 0; k--) r_delay[k] <= r_delay[k-1];
                        r_acc    <= '0;
                        r_tap    <= '0;
                        r_filter <= '0;
                    end
                end
                S_MAC: begin
                    if (r_tap == LAST_TAP) begin
                        o_result    <= w_sum;
                        o_filter_id <= r_filter;
                        o_valid     <= 1'b1;
                    end else begin
                        r_acc <= w_sum;
                        r_tap <= r_tap + 1'b1;
                    end
                end
                S_OUT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        if (r_filter != LAST_FLT) begin
                            r_filter <= r_filter + 1'b1;
                            r_tap    <= '0;
                            r_acc    <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIR_SEQ_STALL_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_stall_cnt <= '0;
        else if (i_sample_valid && !o_sample_ready && o_stall_cnt != 16'hFFFF)
            o_stall_cnt <= o_stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: 8-bit, 3 taps, 2 filters; f0 = {1,1,1}, f1 = {1,2,3}.
module tb_fir_mac_sequencer;

    localparam int B     = 8;
    localparam int NE    = 3;
    localparam int NF    = 2;
    localparam int ACC_W = 18;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [B-1:0]       smp = '0;
    logic               sv = 1'b0;
    logic               sr;
    logic [NF*NE*B-1:0] coeffs;
    logic [ACC_W-1:0]   res;
    logic [0:0]         fid;
    logic               ov;
    logic               rdy = 1'b0;
`ifdef FIR_SEQ_STALL_CNT_EN
    logic [15:0]        stall;
`endif

    fir_mac_sequencer #(.BITS_PER_ELEM(B), .NUM_ELEM(NE), .NUM_FILTERS(NF)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample(smp), .i_sample_valid(sv),
        .o_sample_ready(sr), .i_coeffs(coeffs), .o_result(res), .o_filter_id(fid),
        .o_valid(ov), .i_ready(rdy)
`ifdef FIR_SEQ_STALL_CNT_EN
        , .o_stall_cnt(stall)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n_rx  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [0:0]       id;
        logic [ACC_W-1:0] val;
    } exp_t;
    exp_t         q[$];
    logic [B-1:0] mdl[NE];
    logic [B-1:0] cf[NF][NE];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_coeffs();
        for (int f = 0; f < NF; f++)
            for (int k = 0; k < NE; k++)
                coeffs[B*(f*NE+k) +: B] = cf[f][k];
    endtask

    // Reference model: full dot product per filter over the bench's own delay line.
    task automatic model_accept(input logic [B-1:0] s);
        logic [31:0] sum;
        exp_t e;
        for (int k = NE - 1; k > 0; k--) mdl[k] = mdl[k-1];
        mdl[0] = s;
        for (int f = 0; f < NF; f++) begin
            sum = 0;
            for (int k = 0; k < NE; k++) sum += 32'(cf[f][k]) * 32'(mdl[k]);
            e.id  = 1'(f);
            e.val = ACC_W'(sum);
            q.push_back(e);
        end
    endtask

    task automatic push(input logic [B-1:0] s, output int acc_cyc);
        for (int i = 0; i < 60 && !sr; i++) tick();
        if (!sr) chk("ready_timeout", 32'(sr), 1);
        sv  = 1'b1;
        smp = s;
        tick();
        acc_cyc = cyc;
        sv = 1'b0;
        model_accept(s);
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 400 && n_rx < n; i++) tick();
        if (n_rx < n) chk("rx_timeout", 32'(n_rx), 32'(n));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ov && rdy) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 32'(res), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("result_id", 32'(fid), 32'(e.id));
                chk("result_val", 32'(res), 32'(e.val));
            end
            n_rx++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_acc;
        int t;
        for (int k = 0; k < NE; k++) begin
            cf[0][k] = 8'd1;
            cf[1][k] = 8'(k + 1);
            mdl[k]   = '0;
        end
        load_coeffs();

        // Reset state, while held and after release
        tick(); tick();
        chk("rst_valid", 32'(ov), 0);
        chk("rst_result", 32'(res), 0);
        chk("rst_id", 32'(fid), 0);
        chk("rst_ready", 32'(sr), 1);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 32'(sr), 1);
        chk("idle_valid", 32'(ov), 0);

        // 10,20,30 -> (0,10)(1,10) (0,30)(1,40) (0,60)(1,100), with timing on the first
        rdy = 1'b1;
        push(8'd10, e_acc);
        chk("ready_low_in_mac", 32'(sr), 0);
        t = 0;
        while (!ov && t < 20) begin tick(); t++; end
        chk("valid_latency", 32'(cyc - e_acc), 3);
        t = 0;
        while (!sr && t < 40) begin tick(); t++; end
        chk("ready_return", 32'(cyc - e_acc), 8);
        push(8'd20, e_acc);
        push(8'd30, e_acc);
        wait_rx(6);

        // Back-pressure: delay {40,30,20} -> f0=90 held for 5 cycles
        rdy = 1'b0;
        push(8'd40, e_acc);
        t = 0;
        while (!ov && t < 20) begin tick(); t++; end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 32'(ov), 1);
            chk("hold_val", 32'(res), 32'(q[0].val));
            chk("hold_id", 32'(fid), 32'(q[0].id));
        end
        rdy = 1'b1;
        wait_rx(8);

        // Full scale: all 255 -> 195075 for both filters
        tick();
        for (int f = 0; f < NF; f++)
            for (int k = 0; k < NE; k++) cf[f][k] = 8'hFF;
        load_coeffs();
        for (int i = 0; i < 3; i++) push(8'hFF, e_acc);
        wait_rx(14);

        // Reset mid-MAC discards the partial result and clears the delay line
        tick();
        for (int k = 0; k < NE; k++) begin
            cf[0][k] = 8'd1;
            cf[1][k] = 8'(k + 1);
        end
        load_coeffs();
        push(8'd77, e_acc);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(ov), 0);
        chk("midrst_result", 32'(res), 0);
        chk("midrst_id", 32'(fid), 0);
        chk("midrst_ready", 32'(sr), 1);
        q.delete();
        for (int k = 0; k < NE; k++) mdl[k] = '0;
        tick();
        rst_n = 1'b1;
        tick();
        push(8'd10, e_acc);
        wait_rx(16);

        // Random samples against the model
        for (int i = 0; i < 6; i++) push(8'($urandom_range(0, 255)), e_acc);
        wait_rx(28);

`ifdef FIR_SEQ_STALL_CNT_EN
        // Source holds valid through one full sample period: 8 stalled cycles
        for (int i = 0; i < 40 && !sr; i++) tick();
        chk("stall_start", 32'(stall), 0);
        sv  = 1'b1;
        smp = 8'd5;
        tick();
        model_accept(8'd5);
        for (int i = 0; i < 8; i++) tick();
        sv = 1'b0;
        chk("stall_cnt", 32'(stall), 8);
        wait_rx(30);
`endif

        tick();
        chk("queue_empty", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
